// File: rtl/dmem_responder.sv
// Direct-mapped, write-through, no-write-allocate byte cache for the MEM stage.
// Load hits return data in the same cycle; every other access goes through the backing memory.
module dmem_responder #(
    parameter int          IDX_BITS        = 4,
    parameter logic [15:0] MISS_COUNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        hit,
    output logic [7:0]  rdata,
    output logic        bmem_req,
    output logic        bmem_we,
    output logic [31:0] bmem_addr,
    output logic [7:0]  bmem_wdata,
    input  logic        bmem_ack,
    input  logic [7:0]  bmem_rdata,
    output logic [15:0] miss_count
);

    localparam int DEPTH    = 1 << IDX_BITS;
    localparam int TAG_BITS = 32 - IDX_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]          state_q;
    logic [7:0]          rdata_q;
    logic [DEPTH-1:0]    line_valid;
    logic [TAG_BITS-1:0] line_tag  [DEPTH];
    logic [7:0]          line_data [DEPTH];

    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] cap_idx;
    logic [TAG_BITS-1:0] cap_tag;
    logic                lookup_hit;
    logic                cap_match;
    logic                in_idle;
    logic                load_hit;
    logic                start_fill;
    logic                start_write;
    logic                fill_done;
    logic                write_done;

    // The registered backing-memory address doubles as the captured request address.
    assign req_idx = req_addr[IDX_BITS-1:0];
    assign req_tag = req_addr[31:IDX_BITS];
    assign cap_idx = bmem_addr[IDX_BITS-1:0];
    assign cap_tag = bmem_addr[31:IDX_BITS];

    assign lookup_hit  = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign cap_match   = line_valid[cap_idx] && (line_tag[cap_idx] == cap_tag);
    assign in_idle     = (state_q == S_IDLE);
    assign load_hit    = in_idle && req_valid && !req_we && lookup_hit;
    assign start_fill  = in_idle && req_valid && !req_we && !lookup_hit;
    assign start_write = in_idle && req_valid && req_we;
    assign fill_done   = (state_q == S_FILL) && bmem_ack;
    assign write_done  = (state_q == S_WRITE) && bmem_ack;

    assign hit = load_hit || (state_q == S_RESP);

    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        rdata = 8'h00;
        if (load_hit) begin
            rdata = line_data[req_idx];
        end else if (state_q == S_RESP) begin
            rdata = rdata_q;
        end
    end

    // NOTE: line tag/data storage carries no reset; the valid bits alone decide liveness.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            line_data[cap_idx] <= bmem_rdata;
            line_tag[cap_idx]  <= cap_tag;
        end else if (write_done && cap_match) begin
            line_data[cap_idx] <= bmem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            line_valid <= '0;
            rdata_q    <= 8'h00;
            bmem_req   <= 1'b0;
            bmem_we    <= 1'b0;
            bmem_addr  <= 32'h0;
            bmem_wdata <= 8'h00;
            miss_count <= MISS_COUNT_INIT;
        end else begin
            // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
            case (state_q)
                S_IDLE: begin
                    if (start_fill || start_write) begin
                        state_q    <= start_write ? S_WRITE : S_FILL;
                        bmem_req   <= 1'b1;
                        bmem_we    <= req_we;
                        bmem_addr  <= req_addr;
                        bmem_wdata <= req_we ? req_wdata : 8'h00;
                        if (miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (bmem_ack) begin
                        line_valid[cap_idx] <= 1'b1;
                        rdata_q             <= bmem_rdata;
                        bmem_req            <= 1'b0;
                        state_q             <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (bmem_ack) begin
                        rdata_q  <= 8'h00;
                        bmem_req <= 1'b0;
                        state_q  <= S_RESP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a behavioural cache/backing-memory model predicts every response.
// A second instance starts its miss counter near the top to exercise saturation.
module tb_dmem_responder;

    localparam int          IDX      = 4;
    localparam int          LINES    = 1 << IDX;
    localparam logic [15:0] SAT_INIT = 16'hFFF0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        bmem_ack;
    logic [7:0]  bmem_rdata;

    logic        hit;
    logic [7:0]  rdata;
    logic        bmem_req;
    logic        bmem_we;
    logic [31:0] bmem_addr;
    logic [7:0]  bmem_wdata;
    logic [15:0] miss_count;

    logic        s_hit;
    logic [7:0]  s_rdata;
    logic        s_bmem_req;
    logic        s_bmem_we;
    logic [31:0] s_bmem_addr;
    logic [7:0]  s_bmem_wdata;
    logic [15:0] s_miss_count;

    int n_vec = 0;
    int n_err = 0;
    int n_miss = 0;

    logic        m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    logic [7:0]  m_data  [LINES];
    logic [7:0]  bmem_mem [logic [31:0]];
    logic [27:0] tag_pool [3] = '{28'h0000000, 28'h0000001, 28'hFFFFFFF};

    dmem_responder #(.IDX_BITS(IDX)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .hit(hit), .rdata(rdata),
        .bmem_req(bmem_req), .bmem_we(bmem_we), .bmem_addr(bmem_addr), .bmem_wdata(bmem_wdata),
        .bmem_ack(bmem_ack), .bmem_rdata(bmem_rdata),
        .miss_count(miss_count)
    );

    dmem_responder #(.IDX_BITS(IDX), .MISS_COUNT_INIT(SAT_INIT)) dut_sat (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .hit(s_hit), .rdata(s_rdata),
        .bmem_req(s_bmem_req), .bmem_we(s_bmem_we), .bmem_addr(s_bmem_addr), .bmem_wdata(s_bmem_wdata),
        .bmem_ack(bmem_ack), .bmem_rdata(bmem_rdata),
        .miss_count(s_miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mem_read(input logic [31:0] a);
        if (!bmem_mem.exists(a)) begin
            bmem_mem[a] = 8'($urandom);
        end
        return bmem_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'h0;
            m_data[i]  = 8'h00;
        end
    endtask

    task automatic check_counts();
        int sat_exp;
        sat_exp = int'(SAT_INIT) + n_miss;
        if (sat_exp > 65535) sat_exp = 65535;
        check("miss_count", 32'(miss_count), 32'(n_miss));
        check("miss_count_sat", 32'(s_miss_count), 32'(sat_exp));
    endtask

    // Called just after a rising edge; returns just after a rising edge with the DUT idle.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                             input int k, input logic drop);
        int          idx;
        logic [31:0] tag;
        logic        exp_hit;
        logic [7:0]  fill;
        idx     = int'(addr[IDX-1:0]);
        tag     = addr >> IDX;
        exp_hit = !we && m_valid[idx] && (m_tag[idx] == tag);
        fill    = 8'h00;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        check("hit_c0", 32'(hit), 32'(exp_hit));
        if (exp_hit) begin
            check("load_hit_rdata", 32'(rdata), 32'(m_data[idx]));
            check("load_hit_bmem_req", 32'(bmem_req), 32'h0);
            step();
            req_valid = 1'b0;
        end else begin
            check("miss_rdata_c0", 32'(rdata), 32'h0);
            n_miss++;
            for (int c = 1; c <= k; c++) begin
                step();
                if (drop && c == 1) begin
                    req_valid = 1'b0;
                    req_we    = 1'($urandom);
                    req_addr  = $urandom;
                    req_wdata = 8'($urandom);
                end
                if (c == k) begin
                    bmem_ack   = 1'b1;
                    bmem_rdata = we ? 8'($urandom) : mem_read(addr);
                    if (!we) fill = bmem_rdata;
                end
                @(negedge clk);
                check("bmem_req_held", 32'(bmem_req), 32'h1);
                check("bmem_we_held", 32'(bmem_we), 32'(we));
                check("bmem_addr_held", bmem_addr, addr);
                if (we) check("bmem_wdata_held", 32'(bmem_wdata), 32'(wd));
                check("stall_hit", 32'(hit), 32'h0);
                check("stall_rdata", 32'(rdata), 32'h0);
                if (c == 1) check_counts();
            end
            step();
            bmem_ack   = 1'b0;
            bmem_rdata = 8'($urandom);
            @(negedge clk);
            check("resp_hit", 32'(hit), 32'h1);
            check("resp_rdata", 32'(rdata), we ? 32'h0 : 32'(fill));
            check("resp_bmem_req", 32'(bmem_req), 32'h0);
            if (we) begin
                bmem_mem[addr] = wd;
                if (m_valid[idx] && m_tag[idx] == tag) m_data[idx] = wd;
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = fill;
            end
            step();
            req_valid = 1'b0;
        end
    endtask

    task automatic stray_ack();
        req_valid  = 1'b0;
        bmem_ack   = 1'b1;
        bmem_rdata = 8'($urandom);
        @(negedge clk);
        check("stray_hit", 32'(hit), 32'h0);
        check("stray_rdata", 32'(rdata), 32'h0);
        step();
        bmem_ack = 1'b0;
        @(negedge clk);
        check("stray_bmem_req", 32'(bmem_req), 32'h0);
        check("stray_hit_after", 32'(hit), 32'h0);
        check_counts();
        step();
    endtask

    task automatic random_run(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = {tag_pool[$urandom_range(0, 2)], 4'($urandom_range(0, LINES - 1))};
            if ($urandom_range(0, 19) == 0) stray_ack();
            do_access($urandom_range(0, 3) == 0, a, 8'($urandom), $urandom_range(1, 4),
                      $urandom_range(0, 4) == 0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        model_clear();
        reset      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h13;
        req_wdata  = 8'h00;
        bmem_ack   = 1'b0;
        bmem_rdata = 8'h00;

        @(negedge clk);
        check("rst_hit", 32'(hit), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_bmem_req", 32'(bmem_req), 32'h0);
        check("rst_bmem_we", 32'(bmem_we), 32'h0);
        check("rst_bmem_addr", bmem_addr, 32'h0);
        check("rst_bmem_wdata", 32'(bmem_wdata), 32'h0);
        check_counts();
        #2;
        reset     = 1'b1;
        req_valid = 1'b0;
        step();

        // Cold load, repeat hit, store-through, non-allocating store, eviction.
        bmem_mem[32'h13] = 8'hA5;
        do_access(1'b0, 32'h13, 8'h00, 3, 1'b0);
        do_access(1'b0, 32'h13, 8'h00, 1, 1'b0);
        do_access(1'b1, 32'h13, 8'h3C, 2, 1'b0);
        do_access(1'b0, 32'h13, 8'h00, 1, 1'b0);
        do_access(1'b1, 32'h20, 8'h77, 1, 1'b0);
        do_access(1'b0, 32'h20, 8'h00, 2, 1'b0);
        do_access(1'b0, 32'h23, 8'h00, 2, 1'b0);
        do_access(1'b0, 32'h13, 8'h00, 1, 1'b0);
        stray_ack();

        random_run(300);

        // Reset in the middle of a fill, then a late acknowledge.
        ra = {28'h5555555, 4'($urandom_range(0, LINES - 1))};
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = ra;
        @(negedge clk);
        check("pre_rst_hit", 32'(hit), 32'h0);
        step();
        @(negedge clk);
        check("pre_rst_bmem_req", 32'(bmem_req), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_bmem_req", 32'(bmem_req), 32'h0);
        check("mid_rst_hit", 32'(hit), 32'h0);
        check("mid_rst_bmem_addr", bmem_addr, 32'h0);
        model_clear();
        n_miss    = 0;
        req_valid = 1'b0;
        check_counts();
        step();
        reset      = 1'b1;
        bmem_ack   = 1'b1;
        bmem_rdata = 8'($urandom);
        @(negedge clk);
        check("late_ack_bmem_req", 32'(bmem_req), 32'h0);
        check("late_ack_hit", 32'(hit), 32'h0);
        step();
        bmem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_hit", 32'(hit), 32'h0);
        check("post_rst_bmem_req", 32'(bmem_req), 32'h0);
        check_counts();
        step();
        do_access(1'b0, 32'h13, 8'h00, 1, 1'b0);

        random_run(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
